// File: rtl/sipo_ctrl_pkg.sv
// rtl/sipo_ctrl_pkg.sv - shared state encoding and counter sizing for the framed SIPO controller
package sipo_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_PARITY
   } sipo_state_t;

   // Counter must be able to hold WIDTH itself (the parity cycle follows the last data bit).
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// rtl/sipo_shift_core.sv - WIDTH-bit MSB-first shift register, advanced only when shift_en is high
module sipo_shift_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic             si,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (shift_en) begin
         q <= {q[WIDTH-2:0], si};
      end
   end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// rtl/sipo_frame_ctrl.sv - frame-aware serial-to-parallel controller with optional even parity
// and a single-entry valid/ready output register that drops words on overrun.
module sipo_frame_ctrl
   import sipo_ctrl_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit PARITY_EN = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             si,
   input  logic             sof,
   output logic [WIDTH-1:0] po_data,
   output logic             po_valid,
   input  logic             po_ready,
   output logic             busy,
   output logic             par_err,
   output logic             overrun
);

   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   sipo_state_t      state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sh;
   logic             shift_en;
   logic             done;
   logic [WIDTH-1:0] word;
   logic             perr;

   sipo_shift_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shift_en),
      .si       (si),
      .q        (sh)
   );

   // Datapath decode: the register shifts on every frame cycle, including the
   // parity cycle, so a sof landing there already captures bit 0 of the next frame.
   always_comb begin
      shift_en = 1'b0;
      done     = 1'b0;
      word     = sh;
      perr     = 1'b0;
      case (state)
         ST_IDLE: begin
            shift_en = sof;
         end
         ST_SHIFT: begin
            shift_en = 1'b1;
            if (cnt == LAST && !PARITY_EN) begin
               done = 1'b1;
               word = {sh[WIDTH-2:0], si};
            end
         end
         ST_PARITY: begin
            shift_en = 1'b1;
            done     = 1'b1;
            word     = sh;
            perr     = ^sh ^ si;
         end
         default: begin
            shift_en = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         po_data  <= '0;
         po_valid <= 1'b0;
         par_err  <= 1'b0;
         overrun  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (done) begin
            if (!po_valid || po_ready) begin
               po_data  <= word;
               par_err  <= perr;
               po_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (po_valid && po_ready) begin
            po_valid <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (sof) begin
                  state <= ST_SHIFT;
                  cnt   <= CW'(1);
                  busy  <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (done) begin
                  if (sof) begin
                     state <= ST_SHIFT;
                     cnt   <= CW'(1);
                     busy  <= 1'b1;
                  end else begin
                     state <= ST_IDLE;
                     cnt   <= '0;
                     busy  <= 1'b0;
                  end
               end else if (sof) begin
                  // Abort: the current bit restarts the frame, nothing is emitted.
                  state <= ST_SHIFT;
                  cnt   <= CW'(1);
                  busy  <= 1'b1;
               end else if (cnt == LAST) begin
                  state <= ST_PARITY;
                  cnt   <= cnt + 1'b1;
                  busy  <= 1'b1;
               end else begin
                  cnt   <= cnt + 1'b1;
                  busy  <= 1'b1;
               end
            end
            ST_PARITY: begin
               if (sof) begin
                  state <= ST_SHIFT;
                  cnt   <= CW'(1);
                  busy  <= 1'b1;
               end else begin
                  state <= ST_IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
